// File: rtl/segre_pkg.sv
// Shared types for the memory arbiter slice.
// Line/address sizes and the access-size enum used by all requesters.
package segre_pkg;

  localparam int ADDR_SIZE             = 32;
  localparam int CACHE_LINE_SIZE_BYTES = 16;
  localparam int ARB_MAX_PORTS         = 8;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/segre_rr_arbiter.sv
// Combinational grant picker: first requester found searching
// upward from ptr_i, wrapping at N_PORTS-1.
module segre_rr_arbiter
  import segre_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int PTR_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % N_PORTS);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// N-port to single-memory arbiter, one open transaction at a time.
// Define SEGRE_MEM_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int ADDR_W     = ADDR_SIZE,
  parameter int LINE_BYTES = CACHE_LINE_SIZE_BYTES
) (
  input  logic                                  clk_i,
  input  logic                                  rsn_i,
  input  logic [N_PORTS-1:0]                    req_i,
  input  logic [N_PORTS-1:0][ADDR_W-1:0]        req_addr_i,
  input  logic [N_PORTS-1:0]                    req_rd_i,
  input  logic [N_PORTS-1:0]                    req_wr_i,
  input  memop_data_type_e [N_PORTS-1:0]        req_type_i,
  input  logic [N_PORTS-1:0][LINE_BYTES*8-1:0]  req_wr_data_i,
  output logic [N_PORTS-1:0]                    ready_o,
  output logic [LINE_BYTES*8-1:0]               rd_data_o,
  output logic [ADDR_W-1:0]                     mem_addr_o,
  output logic                                  mem_rd_o,
  output logic                                  mem_wr_o,
  output memop_data_type_e                      mem_type_o,
  output logic [LINE_BYTES*8-1:0]               mem_wr_data_o,
  input  logic [LINE_BYTES*8-1:0]               mem_rd_data_i,
  input  logic                                  mem_ready_i,
  output logic [N_PORTS-1:0]                    grant_o,
  output logic                                  busy_o
);

  localparam int PTR_W = $clog2(N_PORTS);
  localparam int LW    = LINE_BYTES * 8;

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_PORTS-1:0] grant_q, grant_d, sel_gnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  memop_data_type_e type_q, type_d;
  logic [LW-1:0]    wdata_q, wdata_d;
  logic             done;

  segre_rr_arbiter #(
    .N_PORTS (N_PORTS),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (sel_gnt)
  );

  assign done = (state_q == BUSY) && mem_ready_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    type_d  = type_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = BUSY;
          grant_d = sel_gnt;
          for (int p = 0; p < N_PORTS; p++) begin
            if (sel_gnt[p]) begin
              addr_d  = req_addr_i[p];
              // a combined read+write is issued as a write
              rd_d    = req_rd_i[p] & ~req_wr_i[p];
              wr_d    = req_wr_i[p];
              type_d  = req_type_i[p];
              wdata_d = req_wr_data_i[p];
`ifdef SEGRE_MEM_ARB_FIXED_PRIO_EN
              ptr_d   = '0;
`else
              ptr_d   = (p == N_PORTS - 1) ? '0 : PTR_W'(p + 1);
`endif
            end
          end
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          state_d = IDLE;
          grant_d = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      type_q  <= WORD;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
    end
  end

  assign ready_o       = done ? grant_q : '0;
  assign rd_data_o     = mem_rd_data_i;
  assign mem_addr_o    = addr_q;
  assign mem_rd_o      = rd_q;
  assign mem_wr_o      = wr_q;
  assign mem_type_o    = type_q;
  assign mem_wr_data_o = wdata_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q == BUSY);

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter with 4 ports:
// directed scenarios plus a randomized run against a reference model.
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  localparam int N  = 4;
  localparam int AW = ADDR_SIZE;
  localparam int LW = CACHE_LINE_SIZE_BYTES * 8;
`ifdef SEGRE_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rsn;
  logic [N-1:0] req, req_rd, req_wr;
  logic [N-1:0][AW-1:0] req_addr;
  memop_data_type_e [N-1:0] req_type;
  logic [N-1:0][LW-1:0] req_wd;
  logic [N-1:0] ready, grant;
  logic [LW-1:0] rd_data, mem_wd, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_rd, mem_wr, mem_ready, busy;
  memop_data_type_e mem_type;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  segre_mem_arbiter #(
    .N_PORTS    (N),
    .ADDR_W     (AW),
    .LINE_BYTES (CACHE_LINE_SIZE_BYTES)
  ) dut (
    .clk_i         (clk),
    .rsn_i         (rsn),
    .req_i         (req),
    .req_addr_i    (req_addr),
    .req_rd_i      (req_rd),
    .req_wr_i      (req_wr),
    .req_type_i    (req_type),
    .req_wr_data_i (req_wd),
    .ready_o       (ready),
    .rd_data_o     (rd_data),
    .mem_addr_o    (mem_addr),
    .mem_rd_o      (mem_rd),
    .mem_wr_o      (mem_wr),
    .mem_type_o    (mem_type),
    .mem_wr_data_o (mem_wd),
    .mem_rd_data_i (mem_rdata),
    .mem_ready_i   (mem_ready),
    .grant_o       (grant),
    .busy_o        (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [AW-1:0] a,
                          input memop_data_type_e t,
                          input logic [LW-1:0] d);
    req[p]      = 1'b1;
    req_rd[p]   = rd;
    req_wr[p]   = wr;
    req_addr[p] = a;
    req_type[p] = t;
    req_wd[p]   = d;
  endtask

  task automatic drop_all();
    req    = '0;
    req_rd = '0;
    req_wr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rsn = 1'b0;
    mem_ready = 1'b0;
    drop_all();
    repeat (2) @(negedge clk);
    rsn = 1'b1;
  endtask

  task automatic test_reset();
    rsn = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, grant, ready, mem_rd, mem_wr} !== '0) begin
      fails++;
      $display("FAIL reset_ctl: got %b req 0",
               {busy, grant, ready, mem_rd, mem_wr});
    end
    tests++;
    if (mem_addr !== '0 || mem_type !== WORD || mem_wd !== '0) begin
      fails++;
      $display("FAIL reset_mem: got addr %h type %0d wd %h req 0/WORD/0",
               mem_addr, mem_type, mem_wd);
    end
    rsn = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, grant} !== '0) begin
      fails++;
      $display("FAIL reset_idle: got %b req 0", {busy, grant});
    end
  endtask

  task automatic test_idle_ready();
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      tests++;
      if ({ready, grant, busy} !== '0) begin
        fails++;
        $display("FAIL idle_ready: got %b req 0", {ready, grant, busy});
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_rr_alternate();
    logic [N-1:0] eg;
    logic [LW-1:0] d;
    int e;
    do_reset();
    set_port(0, 1'b1, 1'b0, 32'h10, WORD, '0);
    set_port(1, 1'b1, 1'b0, 32'h20, WORD, '0);
    for (int k = 0; k < 4; k++) begin
      e = FIXED ? 0 : (k % 2);
      eg = '0;
      eg[e] = 1'b1;
      @(negedge clk);
      tests++;
      if (grant !== eg || busy !== 1'b1) begin
        fails++;
        $display("FAIL rr_grant%0d: got %b busy %b req %b busy 1",
                 k, grant, busy, eg);
      end
      tests++;
      if (mem_addr !== ((e == 0) ? 32'h10 : 32'h20)) begin
        fails++;
        $display("FAIL rr_addr%0d: got %h", k, mem_addr);
      end
      @(negedge clk);
      d = {4{$urandom}};
      mem_ready = 1'b1;
      mem_rdata = d;
      #1;
      tests++;
      if (ready !== eg || rd_data !== d) begin
        fails++;
        $display("FAIL rr_ready%0d: got %b %h req %b %h",
                 k, ready, rd_data, eg, d);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      tests++;
      if ({busy, grant} !== '0) begin
        fails++;
        $display("FAIL rr_gap%0d: got %b req 0", k, {busy, grant});
      end
    end
    req[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL rr_drop0: got %b req 0010", grant);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    drop_all();
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [LW-1:0] d3;
    do_reset();
    d3 = {4{$urandom}};
    set_port(3, 1'b1, 1'b1, 32'h300, HALF, d3);
    @(negedge clk);
    tests++;
    if (grant !== 4'b1000) begin
      fails++;
      $display("FAIL wrap_g3: got %b req 1000", grant);
    end
    tests++;
    if ({mem_rd, mem_wr} !== 2'b01 || mem_type !== HALF || mem_wd !== d3) begin
      fails++;
      $display("FAIL rdwr_as_wr: got rd %b wr %b type %0d wd %h req 0 1 HALF %h",
               mem_rd, mem_wr, mem_type, mem_wd, d3);
    end
    set_port(0, 1'b1, 1'b0, 32'h40, WORD, '0);
    mem_ready = 1'b1;
    #1;
    tests++;
    if (ready !== 4'b1000) begin
      fails++;
      $display("FAIL wrap_rdy3: got %b req 1000", ready);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0001 || mem_addr !== 32'h40) begin
      fails++;
      $display("FAIL wrap_next: got %b %h req 0001 00000040", grant, mem_addr);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    drop_all();
    @(negedge clk);
  endtask

  task automatic test_read_byte();
    logic [LW-1:0] ab;
    ab = {16{8'hAB}};
    do_reset();
    set_port(1, 1'b1, 1'b0, 32'h100, BYTE, '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) drop_all();
      #1;
      tests++;
      if (mem_addr !== 32'h100 || {mem_rd, mem_wr} !== 2'b10 ||
          mem_type !== BYTE || grant !== 4'b0010 ||
          ready !== '0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL byte_hold%0d: got %h %b%b %0d %b %b %b",
                 c, mem_addr, mem_rd, mem_wr, mem_type, grant, ready, busy);
      end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = ab;
    #1;
    tests++;
    if (ready !== 4'b0010 || rd_data !== ab) begin
      fails++;
      $display("FAIL byte_done: got %b %h req 0010 %h", ready, rd_data, ab);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    tests++;
    if ({ready, busy, mem_rd} !== '0) begin
      fails++;
      $display("FAIL byte_after: got %b req 0", {ready, busy, mem_rd});
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    set_port(2, 1'b0, 1'b1, 32'h200, WORD, {4{$urandom}});
    @(negedge clk);
    tests++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rb_grant: got %b %b req 0100 1", grant, busy);
    end
    drop_all();
    set_port(1, 1'b1, 1'b0, 32'h11, WORD, '0);
    set_port(3, 1'b1, 1'b0, 32'h33, WORD, '0);
    #2;
    rsn = 1'b0;
    #1;
    tests++;
    if ({busy, grant, ready, mem_rd, mem_wr} !== '0 ||
        mem_addr !== '0 || mem_type !== WORD) begin
      fails++;
      $display("FAIL rb_async: got %b addr %h type %0d",
               {busy, grant, ready, mem_rd, mem_wr}, mem_addr, mem_type);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    rsn = 1'b1;
    #1;
    tests++;
    if ({ready, busy, grant} !== '0) begin
      fails++;
      $display("FAIL rb_ignore: got %b req 0", {ready, busy, grant});
    end
    @(negedge clk);
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL rb_ptr0: got %b req 0010", grant);
    end
    mem_ready = 1'b0;
    drop_all();
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic test_random();
    bit m_busy;
    int m_ptr, m_own, served, st, q;
    logic [AW-1:0] m_addr;
    bit m_rd, m_wr;
    memop_data_type_e m_type;
    logic [LW-1:0] m_wd;
    logic [N-1:0] eg;
    do_reset();
    m_busy = 0;
    m_ptr  = 0;
    m_own  = 0;
    served = -1;
    repeat (400) begin
      @(negedge clk);
      eg = '0;
      if (m_busy) eg[m_own] = 1'b1;
      tests++;
      if (busy !== m_busy || grant !== eg ||
          mem_rd !== (m_busy && m_rd) || mem_wr !== (m_busy && m_wr)) begin
        fails++;
        $display("FAIL rnd_ctl: got b%b g%b r%b w%b req b%b g%b r%b w%b",
                 busy, grant, mem_rd, mem_wr,
                 m_busy, eg, m_busy && m_rd, m_busy && m_wr);
      end
      if (m_busy) begin
        tests++;
        if (mem_addr !== m_addr || mem_type !== m_type || mem_wd !== m_wd) begin
          fails++;
          $display("FAIL rnd_fields: got %h %0d %h req %h %0d %h",
                   mem_addr, mem_type, mem_wd, m_addr, m_type, m_wd);
        end
      end
      if (served >= 0) begin
        req[served] = 1'b0;
        served = -1;
      end
      for (int p = 0; p < N; p++)
        if (!req[p] && $urandom_range(0, 3) == 0)
          set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, memop_data_type_e'($urandom_range(0, 2)),
                   {4{$urandom}});
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = {4{$urandom}};
      #1;
      tests++;
      if (ready !== ((m_busy && mem_ready) ? eg : '0)) begin
        fails++;
        $display("FAIL rnd_ready: got %b busy %b mrdy %b",
                 ready, m_busy, mem_ready);
      end
      if (m_busy && mem_ready) begin
        tests++;
        if (rd_data !== mem_rdata) begin
          fails++;
          $display("FAIL rnd_rdata: got %h req %h", rd_data, mem_rdata);
        end
      end
      if (m_busy) begin
        if (mem_ready) begin
          m_busy = 0;
          served = m_own;
        end
      end else if (req != '0) begin
        st = FIXED ? 0 : m_ptr;
        m_own = -1;
        for (int i = 0; i < N; i++) begin
          q = (st + i) % N;
          if (m_own < 0 && req[q]) m_own = q;
        end
        m_busy = 1;
        m_addr = req_addr[m_own];
        m_wr   = req_wr[m_own];
        m_rd   = req_rd[m_own] && !req_wr[m_own];
        m_type = req_type[m_own];
        m_wd   = req_wd[m_own];
        m_ptr  = (m_own + 1) % N;
      end
    end
    drop_all();
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
  endtask

  initial begin
    rsn       = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    req_addr  = '0;
    req_type  = {N{WORD}};
    req_wd    = '0;
    drop_all();
    test_reset();
    test_idle_ready();
    test_rr_alternate();
    test_wrap();
    test_read_byte();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
